// File: rtl/bayer_bin2x2_pkg.sv
// Shared definitions for the 2x2 Bayer binning path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default pixel depth, pixel type, and the raster FSM state codes.
package bayer_bin2x2_pkg;

    localparam int PIX_DEPTH = 12;

    typedef logic [PIX_DEPTH-1:0] pixel_t;

    // Raster tracker states. IDLE waits for a start-of-frame pixel, ACTIVE
    // counts through the frame until the last pixel of the last row.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/bayer_bin2x2_row_delay.sv
// One-row pixel delay line: the tail is the pixel accepted WIDTH shifts earlier.
// Latency: WIDTH accepted pixels from pixel to tail.
// Backpressure: none; only advances when shift is high, holds otherwise.
// Ports: clk, rst_n (synchronous clear to 0), shift (advance one pixel),
//        pixel (new entry), tail (oldest entry, i.e. same column one row up).
module bayer_bin2x2_row_delay #(
    parameter int WIDTH = 1280,
    parameter int DEPTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift,
    input  logic [DEPTH-1:0] pixel,
    output logic [DEPTH-1:0] tail
);

    logic [DEPTH-1:0] mem [WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                mem[i] <= '0;
            end
        end else if (shift) begin
            mem[0] <= pixel;
            for (int i = 1; i < WIDTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign tail = mem[WIDTH-1];

endmodule

// File: rtl/bayer_bin2x2.sv
// 2x2 pixel binning: averages each odd-row/odd-column window into one pixel.
// Latency: one cycle from the accepted firing pixel to out_valid.
// Backpressure: none; input may stall arbitrarily, output is a one-cycle pulse.
// Ports: clk, rst_n (sync, active-low); in_valid/in_sof/in_data raw stream;
//        out_valid/out_data/out_x/out_y binned pixel; frame_done on last output.
module bayer_bin2x2
    import bayer_bin2x2_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int DEPTH  = PIX_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [DEPTH-1:0]              in_data,
    output logic                          out_valid,
    output logic [DEPTH-1:0]              out_data,
    output logic [$clog2(WIDTH/2)-1:0]    out_x,
    output logic [$clog2(HEIGHT/2)-1:0]   out_y,
    output logic                          frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [0:0]       state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;

    logic             accept;
    logic             fire;
    logic             last_col;
    logic             last_pix;
    logic [CW-1:0]    pos_col;
    logic [RW-1:0]    pos_row;

    logic [DEPTH-1:0] tail;
    logic [DEPTH-1:0] cur_prev;
    logic [DEPTH-1:0] up_prev;
    logic [DEPTH+1:0] sum;

    bayer_bin2x2_row_delay #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_row_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (accept),
        .pixel (in_data),
        .tail  (tail)
    );

    always_comb begin
        accept = in_valid && (state == ST_ACTIVE || in_sof);
        // A start-of-frame pixel is always (0,0), even mid-frame: this is
        // the restart path, and it also discards any window in progress
        // because row 0 can never fire.
        pos_col  = in_sof ? '0 : col;
        pos_row  = in_sof ? '0 : row;
        last_col = (pos_col == COL_LAST);
        last_pix = last_col && (pos_row == ROW_LAST);
        fire     = accept && pos_col[0] && pos_row[0];
        // Widen before adding so four full-scale pixels cannot overflow.
        sum = {2'b00, up_prev} + {2'b00, tail} + {2'b00, cur_prev} + {2'b00, in_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            cur_prev   <= '0;
            up_prev    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_x      <= '0;
            out_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= fire;
            frame_done <= fire && last_pix;

            if (fire) begin
                out_data <= sum[DEPTH+1:2];
                out_x    <= pos_col[CW-1:1];
                out_y    <= pos_row[RW-1:1];
            end

            if (accept) begin
                // Left and upper-left neighbours for the next pixel.
                cur_prev <= in_data;
                up_prev  <= tail;

                if (last_pix) begin
                    state <= ST_IDLE;
                    col   <= '0;
                    row   <= '0;
                end else begin
                    state <= ST_ACTIVE;
                    if (last_col) begin
                        col <= '0;
                        row <= pos_row + RW'(1);
                    end else begin
                        col <= pos_col + CW'(1);
                        row <= pos_row;
                    end
                end
            end
        end
    end

endmodule
